// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: keypad M:SS entry, 1 Hz BCD countdown,
// pause/clear handling and a fixed-length end-of-cook alarm.
module microwave_timer_ctrl #(
    parameter int unsigned ALARM_SECS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       digit_valid,
    input  logic [3:0] digit_in,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min,
    output logic       display_en,
    output logic       mag_on,
    output logic       alarm
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StCook   = 3'd2,
        StPaused = 3'd3,
        StDone   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] min_q, min_d;
    logic [3:0] cnt_q, cnt_d;
    logic       display_en_q, mag_on_q, alarm_q;

    logic       time_nonzero;
    logic       start_ok;
    logic       digit_ok;
    logic [3:0] dec_ones, dec_tens, dec_min;
    logic       dec_zero;

    assign time_nonzero = (min_q != 4'd0) || (tens_q != 4'd0) || (ones_q != 4'd0);
    assign start_ok     = start && door_closed && time_nonzero;
    // A digit is refused if it, or the digit about to become sec_tens, is out of range.
    assign digit_ok     = digit_valid && (digit_in <= 4'd9) && (ones_q <= 4'd5);

    always_comb begin
        dec_ones = ones_q - 4'd1;
        dec_tens = tens_q;
        dec_min  = min_q;
        if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            if (tens_q == 4'd0) begin
                dec_tens = 4'd5;
                dec_min  = min_q - 4'd1;
            end else begin
                dec_tens = tens_q - 4'd1;
            end
        end
        dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    end

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (stop_clear) begin
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                    min_d  = 4'd0;
                end else if (digit_ok) begin
                    min_d   = tens_q;
                    tens_d  = ones_q;
                    ones_d  = digit_in;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (stop_clear) begin
                    state_d = StIdle;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    min_d   = 4'd0;
                end else if (start_ok) begin
                    state_d = StCook;
                end else if (digit_ok) begin
                    min_d  = tens_q;
                    tens_d = ones_q;
                    ones_d = digit_in;
                end
            end
            StCook: begin
                if (stop_clear || !door_closed) begin
                    state_d = StPaused;
                end else if (tick_1hz) begin
                    ones_d = dec_ones;
                    tens_d = dec_tens;
                    min_d  = dec_min;
                    if (dec_zero) begin
                        state_d = StDone;
                        cnt_d   = 4'(ALARM_SECS);
                    end
                end
            end
            StPaused: begin
                if (stop_clear) begin
                    state_d = StIdle;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    min_d   = 4'd0;
                end else if (start_ok) begin
                    state_d = StCook;
                end
            end
            StDone: begin
                if (stop_clear) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (tick_1hz) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                ones_d  = 4'd0;
                tens_d  = 4'd0;
                min_d   = 4'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Flags are decoded from the next state so they land on the same edge as the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
            min_q        <= 4'd0;
            cnt_q        <= 4'd0;
            display_en_q <= 1'b0;
            mag_on_q     <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            min_q        <= min_d;
            cnt_q        <= cnt_d;
            display_en_q <= (state_d != StIdle);
            mag_on_q     <= (state_d == StCook);
            alarm_q      <= (state_d == StDone);
        end
    end

    assign sec_ones   = ones_q;
    assign sec_tens   = tens_q;
    assign min        = min_q;
    assign display_en = display_en_q;
    assign mag_on     = mag_on_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl; observed vector is
// {min, sec_tens, sec_ones, display_en, mag_on, alarm}.
module tb_microwave_timer_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       digit_valid;
    logic [3:0] digit_in;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min;
    logic       display_en;
    logic       mag_on;
    logic       alarm;

    int         total;
    int         bad;
    logic [14:0] exp_v;
    logic [14:0] obs;

    assign obs = {min, sec_tens, sec_ones, display_en, mag_on, alarm};

    microwave_timer_ctrl #(.ALARM_SECS(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min         (min),
        .display_en  (display_en),
        .mag_on      (mag_on),
        .alarm       (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        step();
        digit_valid = 1'b0;
        digit_in    = 4'd0;
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic press_stop();
        stop_clear = 1'b1;
        step();
        stop_clear = 1'b0;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        exp_v = {4'd0, 4'd0, 4'd0, 3'b000};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_state obs=%h exp=%h", obs, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_entry();
        key(4'd1);
        key(4'd3);
        key(4'd0);
        exp_v = {4'd1, 4'd3, 4'd0, 3'b100};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL entry_1_30 obs=%h exp=%h", obs, exp_v);
        end
        key(4'd7);
        exp_v = {4'd3, 4'd0, 4'd7, 3'b100};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL entry_3_07 obs=%h exp=%h", obs, exp_v);
        end
        press_stop();
        exp_v = {4'd0, 4'd0, 4'd0, 3'b000};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL setup_clear obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_illegal();
        key(4'd12);
        exp_v = {4'd0, 4'd0, 4'd0, 3'b000};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL key12_idle obs=%h exp=%h", obs, exp_v);
        end
        key(4'd0);
        key(4'd7);
        key(4'd5);
        exp_v = {4'd0, 4'd0, 4'd7, 3'b100};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL key5_after_07 obs=%h exp=%h", obs, exp_v);
        end
        key(4'd12);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL key12_setup obs=%h exp=%h", obs, exp_v);
        end
        press_stop();
    endtask

    task automatic test_countdown();
        key(4'd1);
        key(4'd0);
        key(4'd0);
        press_start();
        exp_v = {4'd1, 4'd0, 4'd0, 3'b110};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL start_1_00 obs=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {4'd0, 4'd5, 4'd9, 3'b110};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL borrow_0_59 obs=%h exp=%h", obs, exp_v);
        end
        for (int i = 0; i < 58; i++) tick();
        exp_v = {4'd0, 4'd0, 4'd1, 3'b110};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL count_0_01 obs=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {4'd0, 4'd0, 4'd0, 3'b101};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL done_entry obs=%h exp=%h", obs, exp_v);
        end
        tick();
        tick();
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL alarm_hold obs=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {4'd0, 4'd0, 4'd0, 3'b000};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL alarm_end obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_door();
        key(4'd3);
        key(4'd0);
        press_start();
        door_closed = 1'b0;
        step();
        exp_v = {4'd0, 4'd3, 4'd0, 3'b100};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL door_pause obs=%h exp=%h", obs, exp_v);
        end
        tick();
        tick();
        press_start();
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL paused_hold obs=%h exp=%h", obs, exp_v);
        end
        door_closed = 1'b1;
        step();
        press_start();
        tick();
        exp_v = {4'd0, 4'd2, 4'd9, 3'b110};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL resume_tick obs=%h exp=%h", obs, exp_v);
        end
        press_stop();
        press_stop();
    endtask

    task automatic test_simultaneous();
        key(4'd1);
        key(4'd0);
        press_start();
        stop_clear = 1'b1;
        tick_1hz   = 1'b1;
        step();
        stop_clear = 1'b0;
        tick_1hz   = 1'b0;
        exp_v = {4'd0, 4'd1, 4'd0, 3'b100};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL stop_and_tick obs=%h exp=%h", obs, exp_v);
        end
        press_stop();
        key(4'd2);
        key(4'd0);
        start       = 1'b1;
        digit_valid = 1'b1;
        digit_in    = 4'd5;
        step();
        start       = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        exp_v = {4'd0, 4'd2, 4'd0, 3'b110};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL start_and_digit obs=%h exp=%h", obs, exp_v);
        end
        press_stop();
        press_stop();
    endtask

    task automatic test_async_reset();
        key(4'd2);
        key(4'd1);
        key(4'd5);
        press_start();
        exp_v = {4'd2, 4'd1, 4'd5, 3'b110};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL cook_2_15 obs=%h exp=%h", obs, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = {4'd0, 4'd0, 4'd0, 3'b000};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL async_reset obs=%h exp=%h", obs, exp_v);
        end
        #1;
        rst_n = 1'b1;
        step();
        press_start();
        tick();
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL restart_needs_entry obs=%h exp=%h", obs, exp_v);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        tick_1hz    = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        start       = 1'b0;
        stop_clear  = 1'b0;
        door_closed = 1'b1;
        test_reset();
        test_entry();
        test_illegal();
        test_countdown();
        test_door();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Sequencing controller for the microwave cook timer. Accepts keypad digit entry, holds the M:SS setpoint, counts it down once per second while cooking, and handles pause, clear and end-of-cook alarm. Its three BCD digit outputs and display enable feed the timer's 4-bit-to-7-output digit decoders directly; `mag_on` drives the magnetron/lamp/turntable enables.

## Interface
- `ALARM_SECS`, default 3: number of `tick_1hz` pulses the DONE alarm stays asserted (1..15).
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick_1hz` input 1: one-`clk`-cycle pulse per second from the prescaler.
- `digit_valid` input 1: one-cycle pulse; `digit_in` is a new keypad digit.
- `digit_in` input 4: keypad digit, binary 0..15.
- `start` input 1: one-cycle pulse, start or resume.
- `stop_clear` input 1: one-cycle pulse, pause or clear.
- `door_closed` input 1: level; 1 when the door is latched.
- `sec_ones` output 4: seconds units, 0..9.
- `sec_tens` output 4: seconds tens, 0..5.
- `min` output 4: minutes, 0..9.
- `display_en` output 1: enable for the digit decoders.
- `mag_on` output 1: cooking active.
- `alarm` output 1: end-of-cook beeper.

## Operation
- States: IDLE, SETUP, COOKING, PAUSED, DONE. All outputs are registered.
- Reset state: IDLE. All digits 0, `display_en`=0, `mag_on`=0, `alarm`=0, alarm counter 0.
- Input priority when several are sampled in the same cycle: `stop_clear` > door open > `start` > `digit_valid` > `tick_1hz`. Only the highest-priority applicable event acts; the rest are dropped.
- Digit entry is accepted in IDLE and SETUP only. An accepted digit moves the FSM to SETUP.
  - The digit shifts in from the right: `min`<=`sec_tens`, `sec_tens`<=`sec_ones`, `sec_ones`<=`digit_in`.
  - The digit is ignored, with no state change, if `digit_in`>9 or the current `sec_ones`>5, because that would make `sec_tens` illegal.
  - The old `min` value is discarded.
- `start`:
  - From SETUP: goes to COOKING if `door_closed`=1 and the time is not 0:00. Otherwise ignored.
  - From PAUSED: same conditions.
  - In all other states: ignored.
- COOKING, on `tick_1hz`, the time decrements by 1 second with BCD borrow:
  - `sec_ones` 0 goes to 9 and borrows from `sec_tens`.
  - `sec_tens` 0 goes to 5 and borrows from `min`.
  - If the result is 0:00, the FSM enters DONE on the same edge.
- COOKING, on `door_closed`=0 or `stop_clear`: goes to PAUSED. Digits are held.
- PAUSED, on `stop_clear`: goes to IDLE and clears the digits to 0.
- SETUP, on `stop_clear`: goes to IDLE and clears the digits.
- Door open in PAUSED, SETUP or IDLE: no effect other than blocking `start`.
- DONE:
  - On entry, `alarm`=1 and the alarm counter loads `ALARM_SECS`.
  - Each `tick_1hz` decrements the counter.
  - When the counter reaches 0, or on `stop_clear`, the FSM goes to IDLE with `alarm`=0.
  - Digits stay at 0:00.
- Output decode:
  - `display_en`=1 in every state except IDLE.
  - `mag_on`=1 only in COOKING.
  - `alarm`=1 only in DONE.
- Illegal state encodings recover to IDLE with digits cleared.

## Timing
- Event sampled at edge N: the state, digits and flags are all updated and visible after edge N. Latency is one cycle.
- The `tick_1hz` that produces 0:00 lands `mag_on`=0 and `alarm`=1 on that same edge.
- `rst_n` low asserted mid-COOKING: all outputs go to their reset values immediately, without waiting for `clk`. Release is sampled on the next `clk` edge.
- Multi-cycle pulses are not required to be supported; each asserted cycle counts as a separate event.

## Test plan
- Entry: digits 1,3,0 from IDLE -> SETUP with `min`=1, `sec_tens`=3, `sec_ones`=0. Next digit 7 -> 3:07.
- Illegal entry:
  - With 0:07 showing, key 5 -> ignored, still 0:07 (`sec_ones` 7 >5).
  - Key 12 -> ignored.
- Countdown with borrow: load 1:00, start, 1 tick -> 0:59, `mag_on`=1. 59 further ticks -> 0:00, DONE, `alarm`=1, `mag_on`=0. `ALARM_SECS`=3 ticks later -> IDLE, `display_en`=0.
- Door interaction:
  - Cooking 0:30, `door_closed`=0 -> PAUSED at 0:30. Ticks while paused do not change the time.
  - `start` with the door still open -> ignored.
  - Door closed, then `start` -> COOKING.
- Simultaneous events:
  - `stop_clear` and `tick_1hz` in the same cycle while COOKING at 0:10 -> PAUSED at 0:10.
  - `start` and `digit_valid` together in SETUP -> COOKING, digit dropped.
- Async reset mid-COOKING at 2:15: digits 0, `mag_on`=0, `display_en`=0 before the next `clk` edge. Restarting afterwards requires fresh entry.
